// File: rtl/percept_pkg.sv
// Shared opcodes, reply codes and FSM encoding for the perceptron command controller.
package percept_pkg;

  localparam logic [7:0] OP_WRW  = 8'h01;
  localparam logic [7:0] OP_WRX  = 8'h02;
  localparam logic [7:0] OP_RUN  = 8'h03;
  localparam logic [7:0] OP_PING = 8'h04;

  localparam logic [7:0] RPL_ACK  = 8'h06;
  localparam logic [7:0] RPL_PING = 8'hA5;
  localparam logic [7:0] RPL_NAK  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ARG1,
    ARG2,
    ARG3,
    EXEC,
    WAIT_DONE,
    SEND,
    WAIT_TX
  } state_t;

  // Number of argument bytes following a legal multi-byte opcode.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRW:  arg_count = 2'd3;
      OP_WRX:  arg_count = 2'd2;
      OP_RUN:  arg_count = 2'd1;
      default: arg_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/percept_timeout.sv
// Inter-byte idle counter: expires after TIMEOUT consecutive enabled, uncleared cycles.
module percept_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/percept_cmd_ctrl.sv
// UART byte-command decoder driving a perceptron bank and returning one reply byte per command.
module percept_cmd_ctrl
  import percept_pkg::*;
#(
  parameter int N_PERCEPT = 4,
  parameter int N_INPUTS  = 4,
  parameter int TIMEOUT   = 100000,
  localparam int SEL_W    = (N_PERCEPT > 1) ? $clog2(N_PERCEPT) : 1,
  localparam int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [SEL_W-1:0]  bank_sel,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [7:0]        bank_wdata,
  output logic              bank_we_w,
  output logic              bank_we_x,
  output logic              bank_start,
  input  logic              bank_done,
  input  logic [7:0]        bank_result,
  output logic              err
);

  state_t     state, state_n;
  logic [7:0] opcode, opcode_n;
  logic [7:0] arg1, arg1_n, arg2, arg2_n, arg3, arg3_n;
  logic [7:0] reply_n;
  logic       seen_busy, seen_busy_n;
  logic       err_n;
  logic       range_err;
  logic       exec_ok;
  logic       in_arg;
  logic       expired;

  assign in_arg = (state == ARG1) || (state == ARG2) || (state == ARG3);

  percept_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (in_arg),
    .expired (expired)
  );

  // Argument layout: WRW p,i,v / WRX i,v / RUN p
  always_comb begin
    range_err = 1'b0;
    case (opcode)
      OP_WRW:  range_err = (32'(arg1) >= N_PERCEPT) || (32'(arg2) >= N_INPUTS);
      OP_WRX:  range_err = (32'(arg1) >= N_INPUTS);
      OP_RUN:  range_err = (32'(arg1) >= N_PERCEPT);
      default: range_err = 1'b0;
    endcase
  end

  always_comb begin
    bank_sel   = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    case (opcode)
      OP_WRW: begin
        bank_sel   = arg1[SEL_W-1:0];
        bank_addr  = arg2[ADDR_W-1:0];
        bank_wdata = arg3;
      end
      OP_WRX: begin
        bank_addr  = arg1[ADDR_W-1:0];
        bank_wdata = arg2;
      end
      OP_RUN:  bank_sel = arg1[SEL_W-1:0];
      default: ;
    endcase
  end

  assign exec_ok    = (state == EXEC) && !range_err;
  assign bank_we_w  = exec_ok && (opcode == OP_WRW);
  assign bank_we_x  = exec_ok && (opcode == OP_WRX);
  assign bank_start = exec_ok && (opcode == OP_RUN);
  assign tx_start   = (state == SEND) && !tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opcode    <= '0;
      arg1      <= '0;
      arg2      <= '0;
      arg3      <= '0;
      tx_data   <= '0;
      seen_busy <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      opcode    <= opcode_n;
      arg1      <= arg1_n;
      arg2      <= arg2_n;
      arg3      <= arg3_n;
      tx_data   <= reply_n;
      seen_busy <= seen_busy_n;
      err       <= err_n;
    end
  end

  // tx_data only changes on entry to SEND, so it stays stable through WAIT_TX.
  always_comb begin
    state_n     = state;
    opcode_n    = opcode;
    arg1_n      = arg1;
    arg2_n      = arg2;
    arg3_n      = arg3;
    reply_n     = tx_data;
    seen_busy_n = seen_busy;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          opcode_n = rx_data;
          case (rx_data)
            OP_PING: begin
              reply_n = RPL_PING;
              state_n = SEND;
            end
            OP_WRW, OP_WRX, OP_RUN: state_n = ARG1;
            default: begin
              reply_n = RPL_NAK;
              err_n   = 1'b1;
              state_n = SEND;
            end
          endcase
        end
      end
      ARG1: begin
        if (rx_valid) begin
          arg1_n  = rx_data;
          state_n = (arg_count(opcode) == 2'd1) ? EXEC : ARG2;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      ARG2: begin
        if (rx_valid) begin
          arg2_n  = rx_data;
          state_n = (arg_count(opcode) == 2'd2) ? EXEC : ARG3;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      ARG3: begin
        if (rx_valid) begin
          arg3_n  = rx_data;
          state_n = EXEC;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      EXEC: begin
        if (range_err) begin
          reply_n = RPL_NAK;
          err_n   = 1'b1;
          state_n = SEND;
        end else if (opcode == OP_RUN) begin
          state_n = WAIT_DONE;
        end else begin
          reply_n = RPL_ACK;
          state_n = SEND;
        end
      end
      WAIT_DONE: begin
        if (bank_done) begin
          reply_n = bank_result;
          state_n = SEND;
        end
      end
      SEND: begin
        seen_busy_n = 1'b0;
        if (!tx_busy) state_n = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_busy) begin
          seen_busy_n = 1'b1;
        end else if (seen_busy) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Bytes arriving while a command is being executed or answered are dropped.
    if (rx_valid && !(state == IDLE || in_arg)) err_n = 1'b1;
  end

endmodule
